// File: rtl/forward_sb.sv
// DE-stage operand forwarding with a long-latency scoreboard, stall generation and a stall watchdog.
// Optional performance counters are compiled in when FWD_PERF_CNT_EN is defined.
module forward_sb #(
   parameter int NUM_RD = 2,
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int WDOG_W = 6
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_RD*AW-1:0]   DE_GRFReadAddr_v,
   output logic [NUM_RD*XLEN-1:0] DE_GRFReadData_v,
   output logic [NUM_RD*AW-1:0]   GRFReadAddr_v,
   input  logic [NUM_RD*XLEN-1:0] GRFReadData_v,
   input  logic                   DE_Issue_1,
   input  logic                   DE_Wen_1,
   input  logic                   DE_Long_1,
   input  logic [AW-1:0]          DE_WriteAddr_5,
   input  logic                   ALU_GRFWen_1,
   input  logic                   ALU_Load_1,
   input  logic [AW-1:0]          ALU_GRFWriteAddr_5,
   input  logic [XLEN-1:0]        ALU_ALUResult_32,
   input  logic                   MEM_GRFWen_1,
   input  logic [AW-1:0]          MEM_GRFWriteAddr_5,
   input  logic [XLEN-1:0]        MEM_GRFWriteData_32,
   input  logic                   LNG_Done_1,
   input  logic [AW-1:0]          LNG_WriteAddr_5,
   input  logic [XLEN-1:0]        LNG_WriteData_32,
   output logic                   Stall_1,
   output logic                   WdogErr_1
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]            PerfLdStall_32,
   output logic [31:0]            PerfSbStall_32
`endif
);

   localparam int                NREG       = 1 << AW;
   localparam logic [WDOG_W-1:0] WDOG_LIMIT = '1;

   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic [NUM_RD-1:0] ld_hit;
   logic [NUM_RD-1:0] raw_hit;
   logic              waw_hit;
   logic              ld_use;
   logic              sb_stall;
   logic              issue_long;
   logic [WDOG_W-1:0] wdog;
   logic [WDOG_W-1:0] wdog_nxt;

   assign GRFReadAddr_v = DE_GRFReadAddr_v;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_port
      logic [AW-1:0]   src;
      logic [XLEN-1:0] fwd;
      logic            nz;
      logic            alu_hit;
      logic            mem_hit;
      logic            lng_hit;

      assign src     = DE_GRFReadAddr_v[i*AW +: AW];
      assign nz      = (src != '0);
      assign alu_hit = ALU_GRFWen_1 & ~ALU_Load_1 & (ALU_GRFWriteAddr_5 == src);
      assign mem_hit = MEM_GRFWen_1 & (MEM_GRFWriteAddr_5 == src);
      assign lng_hit = LNG_Done_1 & (LNG_WriteAddr_5 == src);

      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      always_comb begin
         fwd = GRFReadData_v[i*XLEN +: XLEN];
         if (!nz)          fwd = '0;
         else if (alu_hit) fwd = ALU_ALUResult_32;
         else if (mem_hit) fwd = MEM_GRFWriteData_32;
         else if (lng_hit) fwd = LNG_WriteData_32;
      end

      assign DE_GRFReadData_v[i*XLEN +: XLEN] = fwd;

      // A load in ALU has no data yet; a long op finishing this cycle is forwarded, so no stall.
      assign ld_hit[i]  = nz & ALU_Load_1 & ALU_GRFWen_1 & (ALU_GRFWriteAddr_5 == src);
      assign raw_hit[i] = nz & busy[src] & ~lng_hit;
   end

   assign waw_hit    = DE_Issue_1 & DE_Wen_1 & (DE_WriteAddr_5 != '0) & busy[DE_WriteAddr_5];
   assign ld_use     = |ld_hit;
   assign sb_stall   = (|raw_hit) | waw_hit;
   assign Stall_1    = ld_use | sb_stall;
   assign issue_long = DE_Issue_1 & ~Stall_1 & DE_Wen_1 & DE_Long_1 & (DE_WriteAddr_5 != '0);

   // Clear is applied before set so a same-cycle reissue keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (LNG_Done_1) busy_nxt[LNG_WriteAddr_5] = 1'b0;
      if (issue_long) busy_nxt[DE_WriteAddr_5]  = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // NOTE: the scoreboard is a flop array, not RAM; it must reset so no stale busy bit survives.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
         busy <= busy_nxt;
      end
   end

   always_comb begin
      wdog_nxt = '0;
      if (Stall_1) begin
         wdog_nxt = (wdog == WDOG_LIMIT) ? wdog : wdog + WDOG_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wdog      <= '0;
         WdogErr_1 <= 1'b0;
      end else begin
         wdog <= wdog_nxt;
         if (wdog_nxt == WDOG_LIMIT) WdogErr_1 <= 1'b1;
      end
   end

`ifdef FWD_PERF_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         PerfLdStall_32 <= '0;
         PerfSbStall_32 <= '0;
      end else begin
         if (ld_use)             PerfLdStall_32 <= PerfLdStall_32 + 32'd1;
         if (sb_stall & ~ld_use) PerfSbStall_32 <= PerfSbStall_32 + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_forward_sb.sv
// Scoreboard bench for forward_sb: expected operands and stall are queued as stimulus is
// driven and popped for comparison at the following falling edge.
module tb_forward_sb;

   logic        clk;
   logic        resetn;
   logic [9:0]  DE_GRFReadAddr_v;
   logic [63:0] DE_GRFReadData_v;
   logic [9:0]  GRFReadAddr_v;
   logic [63:0] GRFReadData_v;
   logic        DE_Issue_1, DE_Wen_1, DE_Long_1;
   logic [4:0]  DE_WriteAddr_5;
   logic        ALU_GRFWen_1, ALU_Load_1;
   logic [4:0]  ALU_GRFWriteAddr_5;
   logic [31:0] ALU_ALUResult_32;
   logic        MEM_GRFWen_1;
   logic [4:0]  MEM_GRFWriteAddr_5;
   logic [31:0] MEM_GRFWriteData_32;
   logic        LNG_Done_1;
   logic [4:0]  LNG_WriteAddr_5;
   logic [31:0] LNG_WriteData_32;
   logic        Stall_1;
   logic        WdogErr_1;

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      logic        st;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    errors = 0;
   int    checks = 0;

   forward_sb dut (
      .clk                 (clk),
      .resetn              (resetn),
      .DE_GRFReadAddr_v    (DE_GRFReadAddr_v),
      .DE_GRFReadData_v    (DE_GRFReadData_v),
      .GRFReadAddr_v       (GRFReadAddr_v),
      .GRFReadData_v       (GRFReadData_v),
      .DE_Issue_1          (DE_Issue_1),
      .DE_Wen_1            (DE_Wen_1),
      .DE_Long_1           (DE_Long_1),
      .DE_WriteAddr_5      (DE_WriteAddr_5),
      .ALU_GRFWen_1        (ALU_GRFWen_1),
      .ALU_Load_1          (ALU_Load_1),
      .ALU_GRFWriteAddr_5  (ALU_GRFWriteAddr_5),
      .ALU_ALUResult_32    (ALU_ALUResult_32),
      .MEM_GRFWen_1        (MEM_GRFWen_1),
      .MEM_GRFWriteAddr_5  (MEM_GRFWriteAddr_5),
      .MEM_GRFWriteData_32 (MEM_GRFWriteData_32),
      .LNG_Done_1          (LNG_Done_1),
      .LNG_WriteAddr_5     (LNG_WriteAddr_5),
      .LNG_WriteData_32    (LNG_WriteData_32),
      .Stall_1             (Stall_1),
      .WdogErr_1           (WdogErr_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within 200000 time units");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      DE_GRFReadAddr_v    = '0;
      GRFReadData_v       = '0;
      DE_Issue_1          = 1'b0;
      DE_Wen_1            = 1'b0;
      DE_Long_1           = 1'b0;
      DE_WriteAddr_5      = '0;
      ALU_GRFWen_1        = 1'b0;
      ALU_Load_1          = 1'b0;
      ALU_GRFWriteAddr_5  = '0;
      ALU_ALUResult_32    = '0;
      MEM_GRFWen_1        = 1'b0;
      MEM_GRFWriteAddr_5  = '0;
      MEM_GRFWriteData_32 = '0;
      LNG_Done_1          = 1'b0;
      LNG_WriteAddr_5     = '0;
      LNG_WriteData_32    = '0;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1,
                     input logic [31:0] g0, input logic [31:0] g1);
      DE_GRFReadAddr_v = {a1, a0};
      GRFReadData_v    = {g1, g0};
   endtask

   task automatic issue(input logic [4:0] d, input logic long_op);
      DE_Issue_1     = 1'b1;
      DE_Wen_1       = 1'b1;
      DE_Long_1      = long_op;
      DE_WriteAddr_5 = d;
   endtask

   task automatic lng(input logic [4:0] a, input logic [31:0] d);
      LNG_Done_1       = 1'b1;
      LNG_WriteAddr_5  = a;
      LNG_WriteData_32 = d;
   endtask

   task automatic compare();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_d0"},    {32'b0, DE_GRFReadData_v[31:0]},  {32'b0, e.d0});
      check({t, "_d1"},    {32'b0, DE_GRFReadData_v[63:32]}, {32'b0, e.d1});
      check({t, "_stall"}, {63'b0, Stall_1},                 {63'b0, e.st});
   endtask

   // Inputs are already driven (posedge+1); queue expectations, compare at negedge, advance.
   task automatic cyc(input string tag, input logic [31:0] e0, input logic [31:0] e1, input logic es);
      exp_t e;
      e.d0 = e0;
      e.d1 = e1;
      e.st = es;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0;
      idle();
      #12;
      check("rst_stall", {63'b0, Stall_1},   64'd0);
      check("rst_err",   {63'b0, WdogErr_1}, 64'd0);
      check("rst_data",  DE_GRFReadData_v,   64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Forwarding priority
      idle(); rd(5'd5, 5'd5, 32'hAAAA, 32'hBBBB);
      ALU_GRFWen_1 = 1'b1; ALU_GRFWriteAddr_5 = 5'd5; ALU_ALUResult_32 = 32'h11;
      MEM_GRFWen_1 = 1'b1; MEM_GRFWriteAddr_5 = 5'd5; MEM_GRFWriteData_32 = 32'h22;
      lng(5'd5, 32'h33);
      #1 check("pass_addr", {54'b0, GRFReadAddr_v}, {54'b0, 5'd5, 5'd5});
      cyc("alu_pri", 32'h11, 32'h11, 1'b0);
      idle(); rd(5'd5, 5'd5, 32'hAAAA, 32'hBBBB);
      MEM_GRFWen_1 = 1'b1; MEM_GRFWriteAddr_5 = 5'd5; MEM_GRFWriteData_32 = 32'h22;
      lng(5'd5, 32'h33);
      cyc("mem_pri", 32'h22, 32'h22, 1'b0);
      idle(); rd(5'd5, 5'd5, 32'hAAAA, 32'hBBBB);
      lng(5'd5, 32'h33);
      cyc("lng_pri", 32'h33, 32'h33, 1'b0);
      idle(); rd(5'd5, 5'd6, 32'hAAAA, 32'hBBBB);
      ALU_GRFWen_1 = 1'b1; ALU_GRFWriteAddr_5 = 5'd4; ALU_ALUResult_32 = 32'h44;
      MEM_GRFWen_1 = 1'b1; MEM_GRFWriteAddr_5 = 5'd6; MEM_GRFWriteData_32 = 32'h66;
      cyc("mixed", 32'hAAAA, 32'h66, 1'b0);

      // Load-use
      idle(); rd(5'd3, 5'd7, 32'h3333, 32'h7777);
      ALU_GRFWen_1 = 1'b1; ALU_Load_1 = 1'b1; ALU_GRFWriteAddr_5 = 5'd7; ALU_ALUResult_32 = 32'hDEAD;
      #1 check("pass_addr2", {54'b0, GRFReadAddr_v}, {54'b0, 5'd7, 5'd3});
      cyc("ld_use_p1", 32'h3333, 32'h7777, 1'b1);
      rd(5'd7, 5'd3, 32'h7777, 32'h3333);
      cyc("ld_use_p0", 32'h7777, 32'h3333, 1'b1);
      rd(5'd3, 5'd7, 32'h3333, 32'h7777);
      issue(5'd12, 1'b1);
      cyc("ld_use_iss", 32'h3333, 32'h7777, 1'b1);
      idle(); rd(5'd12, 5'd0, 32'h1212, 32'h0);
      cyc("no_set_stalled", 32'h1212, 32'h0, 1'b0);
      idle(); rd(5'd7, 5'd0, 32'h7777, 32'h0);
      ALU_Load_1 = 1'b1; ALU_GRFWriteAddr_5 = 5'd7;
      cyc("load_no_wen", 32'h7777, 32'h0, 1'b0);

      // Long op RAW / WAW
      idle(); issue(5'd9, 1'b1);
      cyc("lng_issue", 32'h0, 32'h0, 1'b0);
      idle(); rd(5'd9, 5'd0, 32'h9999, 32'h0);
      cyc("raw_p0", 32'h9999, 32'h0, 1'b1);
      idle(); issue(5'd9, 1'b0);
      cyc("waw", 32'h0, 32'h0, 1'b1);
      idle(); rd(5'd0, 5'd9, 32'h0, 32'h9999);
      cyc("raw_p1", 32'h0, 32'h9999, 1'b1);
      idle(); rd(5'd9, 5'd0, 32'h9999, 32'h0); lng(5'd9, 32'hABCD);
      cyc("lng_done", 32'hABCD, 32'h0, 1'b0);
      idle(); rd(5'd9, 5'd9, 32'h9999, 32'h9998);
      cyc("busy_clr", 32'h9999, 32'h9998, 1'b0);

      // Same-cycle clear and set: set wins
      idle(); lng(5'd9, 32'h5555); issue(5'd9, 1'b1);
      cyc("set_clr", 32'h0, 32'h0, 1'b0);
      idle(); rd(5'd0, 5'd9, 32'h0, 32'h9999);
      cyc("set_wins", 32'h0, 32'h9999, 1'b1);
      idle(); rd(5'd0, 5'd9, 32'h0, 32'h9999); lng(5'd9, 32'h4242);
      cyc("set_wins_done", 32'h0, 32'h4242, 1'b0);
      idle(); rd(5'd0, 5'd9, 32'h0, 32'h9999);
      cyc("set_wins_clr", 32'h0, 32'h9999, 1'b0);

      // Register zero
      idle(); rd(5'd0, 5'd0, 32'hFFFF, 32'hEEEE);
      ALU_GRFWen_1 = 1'b1; ALU_Load_1 = 1'b1; ALU_GRFWriteAddr_5 = 5'd0; ALU_ALUResult_32 = 32'h1;
      MEM_GRFWen_1 = 1'b1; MEM_GRFWriteAddr_5 = 5'd0; MEM_GRFWriteData_32 = 32'h2;
      lng(5'd0, 32'h3); issue(5'd0, 1'b1);
      cyc("x0_all", 32'h0, 32'h0, 1'b0);
      idle(); rd(5'd0, 5'd0, 32'hFFFF, 32'hEEEE); issue(5'd0, 1'b1);
      cyc("x0_waw", 32'h0, 32'h0, 1'b0);
      idle(); rd(5'd0, 5'd0, 32'hFFFF, 32'hEEEE);
      ALU_GRFWen_1 = 1'b1; ALU_GRFWriteAddr_5 = 5'd0; ALU_ALUResult_32 = 32'h1;
      cyc("x0_alu", 32'h0, 32'h0, 1'b0);

      // Watchdog: 63 consecutive stall cycles set the sticky error
      idle(); issue(5'd4, 1'b1);
      cyc("wd_issue", 32'h0, 32'h0, 1'b0);
      for (int k = 1; k <= 64; k++) begin
         idle(); rd(5'd4, 5'd0, 32'h4444, 32'h0);
         if (k == 63) check("wd_before", {63'b0, WdogErr_1}, 64'd0);
         if (k == 64) check("wd_hit",    {63'b0, WdogErr_1}, 64'd1);
         cyc("wd_stall", 32'h4444, 32'h0, 1'b1);
      end
      idle();
      cyc("wd_release", 32'h0, 32'h0, 1'b0);
      check("wd_sticky", {63'b0, WdogErr_1}, 64'd1);

      // Asynchronous reset mid-operation drops busy and the error
      idle(); rd(5'd4, 5'd0, 32'h4444, 32'h0);
      #1 check("pre_rst_stall", {63'b0, Stall_1}, 64'd1);
      #1 resetn = 1'b0;
      #1;
      check("async_err",   {63'b0, WdogErr_1}, 64'd0);
      check("async_stall", {63'b0, Stall_1},   64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      idle(); rd(5'd4, 5'd0, 32'h4444, 32'h0);
      cyc("post_rst", 32'h4444, 32'h0, 1'b0);
      idle(); rd(5'd4, 5'd0, 32'h4444, 32'h0); lng(5'd4, 32'h7E7E);
      cyc("late_done", 32'h7E7E, 32'h0, 1'b0);
      idle(); rd(5'd4, 5'd0, 32'h4444, 32'h0);
      cyc("late_done_after", 32'h4444, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
